map_scroll_controller: RTL and testbench

Sequences map scrolling for the delivery game. A single elapsed-time counter is compared against a period derived from the current difficulty level and the player velocity, replacing a set of fixed-period timers and a selector, so a velocity change never drops a scroll step. It also runs the game run/pause/halt state machine, raises the difficulty level on a fixed schedule, and emits one `move_map` pulse per map step to the map datapath.

---
 rtl/map_scroll_controller.sv | 114 +++++++++++
 tb/tb_map_scroll_controller.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/map_scroll_controller.sv
// Map scroll sequencer: run/pause/halt FSM, difficulty ramp and a single
// elapsed counter compared against a speed-dependent scroll period.
module map_scroll_controller #(
   parameter int BASE_PERIOD = 800,
   parameter int STEP        = 100,
   parameter int LEVEL_TIME  = 30000,
   parameter int MAX_LEVEL   = 3,
   parameter int CW          = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       crash,
   input  logic [1:0] velocity,
   output logic       move_map,
   output logic       level_up,
   output logic [1:0] level,
   output logic [2:0] speed,
   output logic       running,
   output logic       halted
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, HALT} state_t;

   localparam logic [CW-1:0] LP_LEVEL_LAST = CW'(LEVEL_TIME - 1);
   localparam logic [1:0]    LP_MAX_LEVEL  = 2'(MAX_LEVEL);

   state_t        r_state;
   state_t        w_nextState;
   logic          w_enterRun;
   logic [CW-1:0] r_elapsed;
   logic [CW-1:0] r_levelTimer;
   logic [1:0]    r_level;
   logic          r_moveMap;
   logic          r_levelUp;
   logic [CW-1:0] w_period;
   logic [CW-1:0] w_periodLast;

   assign speed        = {1'b0, r_level} + {1'b0, velocity};
   assign w_period     = CW'(BASE_PERIOD) - CW'(STEP) * CW'(speed);
   assign w_periodLast = w_period - CW'(1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   // Crash outranks pause; start only matters from IDLE or HALT.
   always_comb begin
      w_nextState = r_state;
      w_enterRun  = 1'b0;
      case (r_state)
         IDLE, HALT: begin
            if (start) begin
               w_nextState = RUN;
               w_enterRun  = 1'b1;
            end
         end
         RUN: begin
            if (crash)      w_nextState = HALT;
            else if (pause) w_nextState = PAUSED;
         end
         PAUSED: begin
            if (crash)       w_nextState = HALT;
            else if (!pause) w_nextState = RUN;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // The >= compare makes a mid-interval speed-up fire on the next edge
   // instead of wrapping past the shorter period and losing a step.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_elapsed    <= '0;
         r_levelTimer <= '0;
         r_level      <= '0;
         r_moveMap    <= 1'b0;
         r_levelUp    <= 1'b0;
      end else begin
         r_moveMap <= 1'b0;
         r_levelUp <= 1'b0;
         if (w_enterRun) begin
            r_elapsed    <= '0;
            r_levelTimer <= '0;
            r_level      <= '0;
         end else if (r_state == RUN) begin
            if (r_elapsed >= w_periodLast) begin
               r_moveMap <= 1'b1;
               r_elapsed <= '0;
            end else begin
               r_elapsed <= r_elapsed + CW'(1);
            end
            if (r_levelTimer == LP_LEVEL_LAST) begin
               r_levelTimer <= '0;
               if (r_level < LP_MAX_LEVEL) begin
                  r_level   <= r_level + 2'd1;
                  r_levelUp <= 1'b1;
               end
            end else begin
               r_levelTimer <= r_levelTimer + CW'(1);
            end
         end
      end
   end

   assign move_map = r_moveMap;
   assign level_up = r_levelUp;
   assign level    = r_level;
   assign running  = (r_state == RUN);
   assign halted   = (r_state == HALT);

endmodule

// File: tb/tb_map_scroll_controller.sv
// Randomized bench for map_scroll_controller, checked against a model that
// derives level from total RUN cycles and tracks time since the last step.
module tb_map_scroll_controller;

   localparam int BASE = 800;
   localparam int STP  = 100;
   localparam int LT   = 400;
   localparam int MAXL = 3;

   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_PAUSED = 2;
   localparam int M_HALT   = 3;

   logic       clock;
   logic       reset;
   logic       start;
   logic       pause;
   logic       crash;
   logic [1:0] velocity;
   logic       move_map;
   logic       level_up;
   logic [1:0] level;
   logic [2:0] speed;
   logic       running;
   logic       halted;

   int assertCount;
   int failCount;

   int mState;
   int mElapsed;
   int mRunCycles;
   int mMove;
   int mUp;
   bit resetPending;

   map_scroll_controller #(
      .BASE_PERIOD(BASE),
      .STEP(STP),
      .LEVEL_TIME(LT),
      .MAX_LEVEL(MAXL),
      .CW(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .pause(pause),
      .crash(crash),
      .velocity(velocity),
      .move_map(move_map),
      .level_up(level_up),
      .level(level),
      .speed(speed),
      .running(running),
      .halted(halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      assertCount++;
      if (observed != expected) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: observed %0d, expected %0d", tag, $time, observed, expected);
      end
   endtask

   function automatic int levelOf(input int runCycles);
      int lv;
      lv = runCycles / LT;
      return (lv > MAXL) ? MAXL : lv;
   endfunction

   // One clock edge of game behaviour, using the inputs the DUT just sampled.
   task automatic modelEdge();
      int per;
      mMove = 0;
      mUp   = 0;
      if (mState == M_RUN) begin
         per = BASE - STP * (levelOf(mRunCycles) + int'(velocity));
         if (mElapsed >= per - 1) begin
            mMove    = 1;
            mElapsed = 0;
         end else begin
            mElapsed++;
         end
         mRunCycles++;
         if ((mRunCycles % LT) == 0 && (mRunCycles / LT) <= MAXL) mUp = 1;
      end
      if ((mState == M_RUN || mState == M_PAUSED) && crash) mState = M_HALT;
      else if (mState == M_RUN && pause) mState = M_PAUSED;
      else if (mState == M_PAUSED && !pause) mState = M_RUN;
      else if ((mState == M_IDLE || mState == M_HALT) && start) begin
         mState     = M_RUN;
         mElapsed   = 0;
         mRunCycles = 0;
      end
   endtask

   task automatic checkAll();
      checkOutput("move_map", int'(move_map), mMove);
      checkOutput("level_up", int'(level_up), mUp);
      checkOutput("level", int'(level), levelOf(mRunCycles));
      checkOutput("speed", int'(speed), levelOf(mRunCycles) + int'(velocity));
      checkOutput("running", int'(running), int'(mState == M_RUN));
      checkOutput("halted", int'(halted), int'(mState == M_HALT));
   endtask

   task automatic modelReset();
      mState     = M_IDLE;
      mElapsed   = 0;
      mRunCycles = 0;
      mMove      = 0;
      mUp        = 0;
   endtask

   task automatic applyStimulus();
      if (mState == M_IDLE || mState == M_HALT) start = ($urandom_range(0, 9) == 0);
      else                                      start = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 299) == 0) pause = ~pause;
      crash = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 149) == 0) velocity = 2'($urandom_range(0, 3));
   endtask

   initial begin
      assertCount  = 0;
      failCount    = 0;
      resetPending = 1'b1;
      modelReset();
      reset    = 1'b0;
      start    = 1'b0;
      pause    = 1'b0;
      crash    = 1'b0;
      velocity = 2'd2;
      #13;
      checkAll();
      checkOutput("resetSpeed", int'(speed), 2);
      reset    = 1'b1;
      velocity = 2'd0;
      @(posedge clock);
      #1;

      for (int cyc = 0; cyc < 20000; cyc++) begin
         applyStimulus();
         @(posedge clock);
         modelEdge();
         #1;
         checkAll();
         if (cyc > 12000 && resetPending && mMove == 1) begin
            #3;
            reset = 1'b0;
            #1;
            checkOutput("asyncMove", int'(move_map), 0);
            checkOutput("asyncLevel", int'(level), 0);
            checkOutput("asyncRunning", int'(running), 0);
            checkOutput("asyncHalted", int'(halted), 0);
            modelReset();
            @(posedge clock);
            #1;
            checkAll();
            reset        = 1'b1;
            resetPending = 1'b0;
         end
      end
      checkOutput("asyncResetReached", int'(resetPending), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
